// File: rtl/serial_pkg.sv
// Shared types and widths for the serial operand path feeding serial_adder_with_vld.
package serial_pkg;

    localparam int SERIAL_W     = 16;
    localparam int SERIAL_LEN_W = $clog2(SERIAL_W + 1);

    typedef logic [SERIAL_W-1:0]     word_t;
    typedef logic [SERIAL_LEN_W-1:0] len_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/serial_operand_serializer.sv
// Parallel-to-serial front end: takes an operand pair over valid/ready and emits it
// LSB-first, one bit pair per enabled cycle, with last marking the final bit.
module serial_operand_serializer
    import serial_pkg::*;
#(
    parameter int W     = SERIAL_W,
    parameter int LEN_W = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a_in,
    input  logic [W-1:0]     b_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic             ser_en,
    output logic             vld,
    output logic             a,
    output logic             b,
    output logic             last,
    output logic             busy
);

    ser_state_e       state_q, state_d;
    logic [W-1:0]     sh_a_q, sh_a_d;
    logic [W-1:0]     sh_b_q, sh_b_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] eff_len;
    logic             accept;

    // Outputs come from registers only, so nothing on a_in/b_in reaches the adder.
    assign busy     = (state_q == SHIFT);
    assign vld      = busy & ser_en;
    assign a        = busy & sh_a_q[0];
    assign b        = busy & sh_b_q[0];
    assign last     = vld & (cnt_q == LEN_W'(1));
    assign in_ready = ~busy | last;
    assign accept   = in_valid & in_ready;

    always_comb begin
        eff_len = len_in;
        if (len_in == '0 || int'(len_in) > W) begin
            eff_len = LEN_W'(W);
        end
    end

    always_comb begin
        // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        cnt_d   = cnt_q;
        if (accept) begin
            // A load on the final bit wins, giving zero-bubble back-to-back words.
            state_d = SHIFT;
            sh_a_d  = a_in;
            sh_b_d  = b_in;
            cnt_d   = eff_len;
        end else if (last) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (vld) begin
            sh_a_d = sh_a_q >> 1;
            sh_b_d = sh_b_q >> 1;
            cnt_d  = cnt_q - LEN_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            cnt_q   <= cnt_d;
        end
    end

    a_last_implies_vld: assert property (@(posedge clk) disable iff (rst)
        last |-> vld);

    a_no_accept_mid_word: assert property (@(posedge clk) disable iff (rst)
        (busy && !(vld && last)) |-> !(in_valid && in_ready));

    a_idle_ready_stable: assert property (@(posedge clk) disable iff (rst)
        (!in_valid && !busy) |=> in_ready);

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Directed and randomized bench for serial_operand_serializer with a scoreboard that
// rebuilds each serial word, adds it bit-serially and compares against a_in+b_in.
module tb_serial_operand_serializer;

    localparam int W     = 8;
    localparam int LEN_W = $clog2(W + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a_in;
    logic [W-1:0]     b_in;
    logic [LEN_W-1:0] len_in;
    logic             ser_en;
    logic             vld;
    logic             a;
    logic             b;
    logic             last;
    logic             busy;

    serial_operand_serializer #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .len_in   (len_in),
        .ser_en   (ser_en),
        .vld      (vld),
        .a        (a),
        .b        (b),
        .last     (last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           len;
    } word_s;

    word_s exp_q[$];
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic int eff_len(input int len);
        return (len == 0 || len > W) ? W : len;
    endfunction

    // Inputs change 1 time unit after posedge; outputs are read 1 unit later.
    task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input int len, input logic en);
        in_valid = v;
        a_in     = av;
        b_in     = bv;
        len_in   = LEN_W'(len);
        ser_en   = en;
        #1;
    endtask

    task automatic tick();
        word_s w;
        if (in_valid && in_ready && !rst) begin
            w.a   = a_in;
            w.b   = b_in;
            w.len = eff_len(int'(len_in));
            exp_q.push_back(w);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: collects bits while vld, closes the word on last and scores it.
    initial begin : monitor
        int           n;
        logic [W-1:0] ga, gb, gs;
        logic         c;
        logic [31:0]  mask;
        word_s        w;
        n = 0; ga = '0; gb = '0; gs = '0; c = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                n = 0; ga = '0; gb = '0; gs = '0; c = 1'b0;
            end else if (vld) begin
                if (n >= W) begin
                    fail("word longer than W without last");
                    n = 0; ga = '0; gb = '0; gs = '0; c = 1'b0;
                end
                ga[n] = a;
                gb[n] = b;
                gs[n] = a ^ b ^ c;
                c     = (a & b) | (a & c) | (b & c);
                n++;
                if (last) begin
                    if (exp_q.size() == 0) begin
                        fail("last with no word outstanding");
                    end else begin
                        w    = exp_q.pop_front();
                        mask = (32'd1 << w.len) - 32'd1;
                        check("word length", 32'(n), 32'(w.len));
                        check("a bits", 32'(ga) & mask, 32'(w.a) & mask);
                        check("b bits", 32'(gb) & mask, 32'(w.b) & mask);
                        check("serial sum", 32'(gs) & mask, (32'(w.a) + 32'(w.b)) & mask);
                    end
                    n = 0; ga = '0; gb = '0; gs = '0; c = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        logic [3:0]   ea, eb;
        logic         pat [7];
        logic [W-1:0] ra, rb;
        int           nv, nl, acc_cycle, idx, budget;
        logic         e;

        rst = 1'b1;
        drive(1'b0, '0, '0, 0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 1);
        check("reset vld", 32'(vld), 0);
        check("reset a", 32'(a), 0);
        check("reset b", 32'(b), 0);
        check("reset last", 32'(last), 0);
        check("reset busy", 32'(busy), 0);
        rst = 1'b0;
        tick();

        // 1: 4-bit word, upper operand bits are garbage that must not leak out
        ea = 4'b1011;
        eb = 4'b0110;
        drive(1'b1, 8'hFB, 8'h56, 4, 1'b1);
        tick();
        drive(1'b0, '0, '0, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("c1 vld bit%0d", i), 32'(vld), 1);
            check($sformatf("c1 a bit%0d", i), 32'(a), 32'(ea[i]));
            check($sformatf("c1 b bit%0d", i), 32'(b), 32'(eb[i]));
            check($sformatf("c1 last bit%0d", i), 32'(last), (i == 3) ? 1 : 0);
            tick();
        end
        check("c1 busy after word", 32'(busy), 0);
        check("c1 in_ready after word", 32'(in_ready), 1);

        // 2: back-to-back words with in_valid held
        drive(1'b1, W'($urandom), W'($urandom), 4, 1'b1);
        tick();
        drive(1'b1, W'($urandom), W'($urandom), 4, 1'b1);
        nv = 0; nl = 0; acc_cycle = -1;
        for (int i = 0; i < 8; i++) begin
            nv += int'(vld);
            nl += int'(last);
            if (in_valid && in_ready) acc_cycle = i;
            tick();
            if (acc_cycle == i) in_valid = 1'b0;
        end
        check("c2 consecutive vld cycles", 32'(nv), 8);
        check("c2 last pulses", 32'(nl), 2);
        check("c2 second accept on last", 32'(acc_cycle), 3);
        check("c2 vld after both words", 32'(vld), 0);

        // 3: single-bit word
        drive(1'b1, 8'h01, 8'h01, 1, 1'b1);
        tick();
        drive(1'b0, '0, '0, 0, 1'b1);
        check("c3 vld", 32'(vld), 1);
        check("c3 last", 32'(last), 1);
        check("c3 a", 32'(a), 1);
        check("c3 b", 32'(b), 1);
        tick();
        check("c3 busy after", 32'(busy), 0);
        check("c3 in_ready after", 32'(in_ready), 1);

        // 4: bubbles inserted by ser_en mid-word
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        drive(1'b1, 8'hFB, 8'h56, 4, 1'b1);
        tick();
        idx = 0;
        for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
            e = (cyc < 7) ? pat[cyc] : 1'b1;
            drive(1'b0, '0, '0, 0, e);
            check($sformatf("c4 vld cyc%0d", cyc), 32'(vld), 32'(e));
            if (e) begin
                check($sformatf("c4 a bit%0d", idx), 32'(a), 32'(ea[idx]));
                check($sformatf("c4 b bit%0d", idx), 32'(b), 32'(eb[idx]));
                check($sformatf("c4 last bit%0d", idx), 32'(last), (idx == 3) ? 1 : 0);
                idx++;
            end else begin
                check($sformatf("c4 last in bubble cyc%0d", cyc), 32'(last), 0);
            end
            tick();
        end
        check("c4 bits delivered", 32'(idx), 4);

        // 5: len above W clamps to W, then reset in flight
        drive(1'b1, W'($urandom), W'($urandom), 9, 1'b1);
        tick();
        drive(1'b0, '0, '0, 0, 1'b1);
        for (int i = 0; i < W; i++) begin
            check($sformatf("c5 vld bit%0d", i), 32'(vld), 1);
            check($sformatf("c5 last bit%0d", i), 32'(last), (i == W - 1) ? 1 : 0);
            tick();
        end
        check("c5 busy after clamped word", 32'(busy), 0);
        drive(1'b1, W'($urandom), W'($urandom), 9, 1'b1);
        tick();
        drive(1'b0, '0, '0, 0, 1'b1);
        tick();
        tick();
        check("c5 vld on bit2", 32'(vld), 1);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        check("c5 vld after rst", 32'(vld), 0);
        check("c5 busy after rst", 32'(busy), 0);
        check("c5 in_ready after rst", 32'(in_ready), 1);

        // 6: random words, lengths and enables against the scoreboard
        for (int k = 0; k < 1500; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            drive($urandom_range(0, 3) != 0, ra, rb,
                  int'($urandom_range(0, (1 << LEN_W) - 1)), $urandom_range(0, 3) != 0);
            tick();
        end
        drive(1'b0, '0, '0, 0, 1'b1);
        budget = 0;
        while ((exp_q.size() != 0 || busy) && budget < 100) begin
            tick();
            budget++;
        end
        if (budget >= 100) fail("drain timeout");
        tick();
        check("c6 scoreboard empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
